// File: rtl/rob_pkg.sv
// Shared types, sizes and pointer helper for the reorder buffer.
package rob_pkg;
   localparam int N_WAY        = 2;
   localparam int N_ROB        = 32;
   localparam int CDB_BITS     = 7;
   localparam int ROB_IDX_BITS = $clog2(N_ROB);
   localparam int LANE_BITS    = $clog2(N_WAY) + 1;
   localparam int CNT_BITS     = ROB_IDX_BITS + 1;

   typedef logic [CDB_BITS-1:0]     tag_t;
   typedef logic [ROB_IDX_BITS-1:0] idx_t;

   typedef struct packed {
      logic valid;
      logic complete;
      tag_t t;
      tag_t told;
   } rob_entry_t;

   // N_ROB is a power of two, so truncation is the modulo.
   function automatic idx_t ptr_add(idx_t ptr, logic [CNT_BITS-1:0] n);
      return ptr + idx_t'(n);
   endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / complete / retire / recovery bundle of the reorder buffer.
interface reorder_buffer_if;
   import rob_pkg::*;

   logic [LANE_BITS-1:0]   dispatch_num;
   tag_t [N_WAY-1:0]       dispatch_t;
   tag_t [N_WAY-1:0]       dispatch_told;
   tag_t [N_WAY-1:0]       cdb_tag;
   logic                   branch_haz;
   idx_t                   branch_idx;
   idx_t                   rob_tail_idx;
   logic [LANE_BITS-1:0]   rob_free_num;
   logic [LANE_BITS-1:0]   retire_num;
   tag_t [N_WAY-1:0]       rob_told;
   tag_t [N_WAY-1:0]       retire_t;
   tag_t [N_ROB-1:0]       free_list_haz;

   modport master (
      output dispatch_num, dispatch_t, dispatch_told, cdb_tag, branch_haz, branch_idx,
      input  rob_tail_idx, rob_free_num, retire_num, rob_told, retire_t, free_list_haz
   );

   modport slave (
      input  dispatch_num, dispatch_t, dispatch_told, cdb_tag, branch_haz, branch_idx,
      output rob_tail_idx, rob_free_num, retire_num, rob_told, retire_t, free_list_haz
   );
endinterface

// File: rtl/rob_retire_select.sv
// In-order scan from head: lane k retires only if every entry up to it is done.
module rob_retire_select
   import rob_pkg::*;
(
   input  logic                   en,
   input  rob_entry_t [N_ROB-1:0] entries,
   input  idx_t                   head,
   output logic [LANE_BITS-1:0]   retire_num,
   output logic [N_WAY-1:0]       lane_vld,
   output idx_t [N_WAY-1:0]       lane_idx
);
   logic go;

   always_comb begin
      go         = en;
      retire_num = '0;
      lane_vld   = '0;
      lane_idx   = '0;
      for (int k = 0; k < N_WAY; k++) begin
         lane_idx[k] = ptr_add(head, CNT_BITS'(k));
         go          = go && entries[lane_idx[k]].valid && entries[lane_idx[k]].complete;
         lane_vld[k] = go;
         if (go) retire_num = retire_num + LANE_BITS'(1);
      end
   end
endmodule

// File: rtl/reorder_buffer.sv
// N_WAY circular reorder buffer: dispatch, CDB complete, in-order retire, mispredict squash.
// Optional ROB_PERF_EN adds retired_count / squash_count counters.
module reorder_buffer
   import rob_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   reorder_buffer_if.slave  rif
`ifdef ROB_PERF_EN
   ,
   output logic [31:0]      retired_count,
   output logic [31:0]      squash_count
`endif
);
   rob_entry_t [N_ROB-1:0] entries, entries_nxt;
   idx_t                   head, tail, br_age;
   logic [CNT_BITS-1:0]    count, count_nxt, space;
   logic [LANE_BITS-1:0]   free_num, disp_n, retire_num;
   logic [N_WAY-1:0]       lane_vld;
   idx_t [N_WAY-1:0]       lane_idx;
   logic [N_ROB-1:0]       squash;

   assign space    = CNT_BITS'(N_ROB) - count;
   assign free_num = (space >= CNT_BITS'(N_WAY)) ? LANE_BITS'(N_WAY) : LANE_BITS'(space);
   assign disp_n   = rif.branch_haz ? '0 :
                     (rif.dispatch_num > free_num) ? free_num : rif.dispatch_num;
   assign br_age   = rif.branch_idx - head;

   rob_retire_select u_sel (
      .en         (!reset),
      .entries    (entries),
      .head       (head),
      .retire_num (retire_num),
      .lane_vld   (lane_vld),
      .lane_idx   (lane_idx)
   );

   // Age relative to head orders entries even when the ROB is full (head == tail).
   always_comb begin
      squash = '0;
      for (int e = 0; e < N_ROB; e++)
         squash[e] = !reset && rif.branch_haz && entries[e].valid &&
                     (idx_t'(idx_t'(e) - head) > br_age);
   end

   always_comb begin
      rif.rob_told      = '0;
      rif.retire_t      = '0;
      rif.free_list_haz = '0;
      for (int k = 0; k < N_WAY; k++) begin
         if (lane_vld[k]) begin
            rif.rob_told[k] = entries[lane_idx[k]].told;
            rif.retire_t[k] = entries[lane_idx[k]].t;
         end
      end
      for (int e = 0; e < N_ROB; e++)
         if (squash[e]) rif.free_list_haz[e] = entries[e].t;
   end

   assign rif.retire_num   = retire_num;
   assign rif.rob_free_num = free_num;
   assign rif.rob_tail_idx = tail;

   always_comb begin
      entries_nxt = entries;
      for (int e = 0; e < N_ROB; e++)
         if (entries[e].valid && !entries[e].complete && !squash[e])
            for (int j = 0; j < N_WAY; j++)
               if (rif.cdb_tag[j] != '0 && rif.cdb_tag[j] == entries[e].t)
                  entries_nxt[e].complete = 1'b1;
      for (int k = 0; k < N_WAY; k++)
         if (lane_vld[k]) entries_nxt[lane_idx[k]] = '0;
      for (int e = 0; e < N_ROB; e++)
         if (squash[e]) entries_nxt[e] = '0;
      for (int i = 0; i < N_WAY; i++) begin
         if (LANE_BITS'(i) < disp_n) begin
            entries_nxt[ptr_add(tail, CNT_BITS'(i))].valid    = 1'b1;
            entries_nxt[ptr_add(tail, CNT_BITS'(i))].complete = (rif.dispatch_t[i] == '0);
            entries_nxt[ptr_add(tail, CNT_BITS'(i))].t        = rif.dispatch_t[i];
            entries_nxt[ptr_add(tail, CNT_BITS'(i))].told     = rif.dispatch_told[i];
         end
      end
      // After recovery the branch is the youngest survivor; retires come off the old end.
      if (rif.branch_haz)
         count_nxt = CNT_BITS'(br_age) + CNT_BITS'(1) - CNT_BITS'(retire_num);
      else
         count_nxt = count + CNT_BITS'(disp_n) - CNT_BITS'(retire_num);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         entries <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
      end else begin
         entries <= entries_nxt;
         head    <= ptr_add(head, CNT_BITS'(retire_num));
         tail    <= rif.branch_haz ? rif.branch_idx + idx_t'(1)
                                   : ptr_add(tail, CNT_BITS'(disp_n));
         count   <= count_nxt;
      end
   end

`ifdef ROB_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         retired_count <= '0;
         squash_count  <= '0;
      end else begin
         retired_count <= retired_count + 32'(retire_num);
         squash_count  <= squash_count + 32'($countones(squash));
      end
   end
`endif

   a_disp_overflow: assert property (@(posedge clock) disable iff (reset)
      !rif.branch_haz |-> rif.dispatch_num <= free_num);
endmodule
